// File: rtl/matmul_unit_pkg.sv
// Shared definitions for the execute-stage matrix-multiply unit: FSM encoding
// and the address constants used to place C after B in memory.
package matmul_unit_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } mmState;

    localparam logic [31:0] WordBytes = 32'd4;

    // C is stored immediately after the N*N words of B.
    function automatic logic [31:0] cOffset(input int n);
        return WordBytes * 32'(n * n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// W-bit signed multiply-accumulate register. The product keeps only its low
// W bits and the running sum wraps modulo 2^W.
module matmul_mac #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] aIn,
    input  logic [W-1:0] bIn,
    output logic [W-1:0] acc
);

    logic signed [W-1:0] aS;
    logic signed [W-1:0] bS;
    logic signed [W-1:0] acc_p1;

    assign aS  = aIn;
    assign bS  = bIn;
    assign acc = acc_p1;

    // Evaluated entirely in W-bit context: truncating multiply, wrapping add.
    function automatic logic signed [W-1:0] wrapMac(
        input logic signed [W-1:0] base,
        input logic signed [W-1:0] x,
        input logic signed [W-1:0] y
    );
        return base + x * y;
    endfunction

    // Stage p1: accumulator; clr restarts the sum with the current product.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p1 <= '0;
        end else if (en) begin
            acc_p1 <= wrapMac(clr ? '0 : acc_p1, aS, bS);
        end
    end

endmodule

// File: rtl/matmul_unit.sv
// Execute-stage matrix multiply: loads NxN matrices A and B, computes C = A x B
// one MAC per cycle and writes C back, stalling E through MatmulBusy.
module matmul_unit
    import matmul_unit_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MatmulStartE,
    input  logic [31:0]  ABaseE,
    input  logic [31:0]  BBaseE,
    output logic         MatmulBusy,
    output logic         MatmulDone,
    output logic [31:0]  MemAddr,
    output logic         MemRE,
    input  logic [W-1:0] MemRData,
    output logic         MemWE,
    output logic [W-1:0] MemWData
);

    localparam int NN        = N * N;
    localparam int LoadReads = 2 * NN;
    localparam int CntW      = $clog2(LoadReads + 1);
    localparam int IdxW      = $clog2(N);
    localparam int ElW       = $clog2(NN);
    localparam logic [31:0] COffset = cOffset(N);

    mmState state;
    mmState nextState;

    logic [CntW-1:0] loadCnt;
    logic [IdxW-1:0] iIdx;
    logic [IdxW-1:0] jIdx;
    logic [IdxW-1:0] kIdx;
    logic [31:0]     aBase;
    logic [31:0]     bBase;

    logic            rdVld_p1;
    logic [CntW-1:0] rdIdx_p1;

    logic [W-1:0] aMem [NN];
    logic [W-1:0] bMem [NN];

    logic         macEn;
    logic         macClr;
    logic [W-1:0] acc;

    logic [ElW-1:0] aSel;
    logic [ElW-1:0] bSel;
    logic [ElW-1:0] cSel;
    logic           lastK;
    logic           lastJ;
    logic           lastI;
    logic           inA;
    logic [31:0]    loadAddr;
    logic [31:0]    storeAddr;

    assign lastK = (kIdx == IdxW'(N - 1));
    assign lastJ = (jIdx == IdxW'(N - 1));
    assign lastI = (iIdx == IdxW'(N - 1));

    assign aSel = ElW'(iIdx) * ElW'(N) + ElW'(kIdx);
    assign bSel = ElW'(kIdx) * ElW'(N) + ElW'(jIdx);
    assign cSel = ElW'(iIdx) * ElW'(N) + ElW'(jIdx);

    // The first N*N reads walk A, the next N*N walk B.
    assign inA       = (loadCnt < CntW'(NN));
    assign loadAddr  = inA ? aBase + 32'(loadCnt) * WordBytes
                           : bBase + 32'(loadCnt - CntW'(NN)) * WordBytes;
    assign storeAddr = bBase + COffset + 32'(cSel) * WordBytes;

    matmul_mac #(
        .W(W)
    ) uMac (
        .clk  (clk),
        .reset(reset),
        .en   (macEn),
        .clr  (macClr),
        .aIn  (aMem[aSel]),
        .bIn  (bMem[bSel]),
        .acc  (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            loadCnt  <= '0;
            iIdx     <= '0;
            jIdx     <= '0;
            kIdx     <= '0;
            aBase    <= '0;
            bBase    <= '0;
            rdVld_p1 <= 1'b0;
            rdIdx_p1 <= '0;
        end else begin
            state    <= nextState;
            rdVld_p1 <= MemRE;
            rdIdx_p1 <= loadCnt;
            case (state)
                IDLE: begin
                    if (MatmulStartE) begin
                        aBase   <= ABaseE;
                        bBase   <= BBaseE;
                        loadCnt <= '0;
                        iIdx    <= '0;
                        jIdx    <= '0;
                        kIdx    <= '0;
                    end
                end
                LOAD:    loadCnt <= loadCnt + CntW'(1);
                COMPUTE: kIdx <= lastK ? '0 : kIdx + IdxW'(1);
                STORE: begin
                    if (lastJ) begin
                        jIdx <= '0;
                        iIdx <= lastI ? '0 : iIdx + IdxW'(1);
                    end else begin
                        jIdx <= jIdx + IdxW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: read data returns one cycle after the strobe and lands in A or B.
    always_ff @(posedge clk) begin
        if (rdVld_p1) begin
            if (rdIdx_p1 < CntW'(NN)) begin
                aMem[ElW'(rdIdx_p1)] <= MemRData;
            end else begin
                bMem[ElW'(rdIdx_p1 - CntW'(NN))] <= MemRData;
            end
        end
    end

    always_comb begin
        nextState  = state;
        MatmulBusy = 1'b0;
        MatmulDone = 1'b0;
        MemRE      = 1'b0;
        MemWE      = 1'b0;
        MemAddr    = '0;
        MemWData   = '0;
        macEn      = 1'b0;
        macClr     = 1'b0;
        case (state)
            IDLE: begin
                // Stall asserts in the very cycle the start is seen.
                if (MatmulStartE) begin
                    MatmulBusy = 1'b1;
                    nextState  = LOAD;
                end
            end
            LOAD: begin
                MatmulBusy = 1'b1;
                if (loadCnt < CntW'(LoadReads)) begin
                    MemRE   = 1'b1;
                    MemAddr = loadAddr;
                end else begin
                    nextState = COMPUTE;
                end
            end
            COMPUTE: begin
                MatmulBusy = 1'b1;
                macEn      = 1'b1;
                macClr     = (kIdx == '0);
                if (lastK) begin
                    nextState = STORE;
                end
            end
            STORE: begin
                MatmulBusy = 1'b1;
                MemWE      = 1'b1;
                MemAddr    = storeAddr;
                MemWData   = acc;
                nextState  = (lastI && lastJ) ? DONE : COMPUTE;
            end
            DONE: begin
                // A start still held in E is deliberately ignored here.
                MatmulDone = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: doc/matmul_unit.md
Name: matmul_unit

Overview:
- Execute-stage matrix-multiply accelerator. Responds to the pipeline controller's MatmulStartE / MatmulBusy handshake.
- Loads two NxN word matrices A and B from data memory and computes C = A x B.
- Writes C back to memory, holding MatmulBusy so the hazard unit stalls E.
- Owns the data-memory port exclusively while busy; an external mux selects it on MatmulBusy.

Parameters:
- N, 2, matrix dimension; legal range 2..4.
- W, 32, word and data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- MatmulStartE  in  1  start request from the E-stage control register; held high while E is stalled.
- ABaseE  in  32  byte address of A (rs1 value), row-major, word-aligned.
- BBaseE  in  32  byte address of B (rs2 value); C base = BBaseE + 4*N*N.
- MatmulBusy  out  1  stall request to the hazard unit.
- MatmulDone  out  1  one-cycle completion pulse.
- MemAddr  out  32  word-aligned byte address.
- MemRE  out  1  read strobe; read data valid on MemRData the next cycle.
- MemRData  in  32  read data.
- MemWE  out  1  write strobe.
- MemWData  out  32  write data.

Behaviour:
- States: IDLE, LOAD, COMPUTE, STORE, DONE.
- Reset: state=IDLE; MatmulBusy, MatmulDone, MemRE, MemWE = 0; MemAddr, MemWData = 0; all counters and the accumulator = 0.
- Reset mid-operation aborts immediately to IDLE. Partially written C is not rolled back.
- MatmulBusy is combinational: (state==IDLE & MatmulStartE) | state in {LOAD, COMPUTE, STORE}. The stall therefore takes effect in the same cycle the start is seen.
- IDLE -> LOAD when MatmulStartE=1. ABaseE and BBaseE are latched at that edge.
- LOAD:
  - Issues 2*N*N consecutive reads, one per cycle: A words k=0..N*N-1, then B words.
  - Address is base + 4*k.
  - Read data is captured one cycle later into local arrays a[N*N] and b[N*N].
  - LOAD lasts 2*N*N+1 cycles so the last read is captured, then -> COMPUTE.
- COMPUTE:
  - For element (i,j), N cycles, one MAC per cycle: acc += a[i*N+k] * b[k*N+j], k=0..N-1.
  - acc is cleared at the start of each element.
  - Arithmetic is signed W-bit; the product is truncated to its low W bits and the sum wraps modulo 2^W. No saturation, no flags.
- STORE:
  - One cycle per element: MemWE=1, MemAddr = CBase + 4*(i*N+j), MemWData = acc.
  - Then advance j, then i. Returns to COMPUTE until (i,j)=(N-1,N-1) is stored, then -> DONE.
- DONE:
  - One cycle: MatmulDone=1, MatmulBusy=0. The pipeline advances at this edge; the next state is IDLE.
  - MatmulStartE is ignored in DONE, so an instruction still held in E is not re-triggered.
- Cycles from the accept edge to DONE: 2*N*N+1 + N*N*(N+1). For N=2 this is 21.
- MatmulStartE is ignored in LOAD, COMPUTE and STORE. ABaseE and BBaseE changes after latch have no effect.
- Back-to-back: a new start seen in IDLE on the cycle after DONE is accepted normally.
- MemRE and MemWE are never both 1. Both are 0 in IDLE and DONE.
- Address arithmetic wraps at 32 bits; misalignment is not checked.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, LOAD=1, COMPUTE=2, STORE=3, DONE=4);
  - the C-offset constant 4*N*N;
  - the word-size constant 4.
- One natural sub-module: matmul_mac. It holds the W-bit multiply-accumulate register with clear and enable, and is instantiated once.

Test Plan:
- A=[[1,2],[3,4]] @0x100, B=[[5,6],[7,8]] @0x110, start one cycle -> C @0x120 = 19,22,43,50. MatmulDone pulses exactly 21 cycles after the accept edge.
- A=-I (0xFFFFFFFF diagonal), B=[[2,3],[4,5]] -> C = -2,-3,-4,-5 (0xFFFFFFFE...). Checks signed wrap.
- A[0]=B[0]=0x00010000, others 0 -> C[0]=0x00000000. Checks truncation of the 2^32 product.
- MatmulStartE held high through the whole stall, ABaseE changed mid-run -> exactly one operation using the original base. MatmulBusy=0 in DONE; no restart; return to IDLE.
- reset asserted during COMPUTE -> next cycle state IDLE, MatmulBusy=0, MemWE=0. A fresh start then completes with correct C.
- Start on the cycle right after DONE with new bases -> second multiply is correct; MemRE/MemWE never both high over both runs.
